// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester request/response channels plus the RAM port bus of ram_port_arbiter.
interface ram_port_arbiter_if #(
    parameter int ADDRESS_SIZE  = 8,
    parameter int DATA_SIZE     = 8,
    parameter int ACCESS_NUMBER = 2,
    parameter int REQ_NUM       = 4
);
    logic [REQ_NUM-1:0]                         req_valid;
    logic [REQ_NUM-1:0]                         req_we;
    logic [REQ_NUM-1:0][ADDRESS_SIZE-1:0]       req_addr;
    logic [REQ_NUM-1:0][DATA_SIZE-1:0]          req_wdata;
    logic [REQ_NUM-1:0]                         req_ready;
    logic [REQ_NUM-1:0]                         rsp_valid;
    logic [REQ_NUM-1:0][DATA_SIZE-1:0]          rsp_data;
    logic [REQ_NUM-1:0]                         o_err;
    logic                                       o_ram_res;
    logic [ACCESS_NUMBER-1:0][ADDRESS_SIZE-1:0] ram_addr;
    logic [ACCESS_NUMBER-1:0][DATA_SIZE-1:0]    ram_wdata;
    logic [ACCESS_NUMBER-1:0]                   ram_we;
    logic [ACCESS_NUMBER-1:0]                   ram_re;
    logic [ACCESS_NUMBER-1:0][DATA_SIZE-1:0]    ram_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_data, o_err, o_ram_res,
               ram_addr, ram_wdata, ram_we, ram_re
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_data, o_err, o_ram_res,
               ram_addr, ram_wdata, ram_we, ram_re
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares ACCESS_NUMBER RAM ports among REQ_NUM requesters with 1-cycle read responses.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 first) instead of round-robin.
module ram_port_arbiter #(
    parameter int ADDRESS_SIZE  = 8,
    parameter int DATA_SIZE     = 8,
    parameter int DATA_LEN      = 256,
    parameter int ACCESS_NUMBER = 2,
    parameter int REQ_NUM       = 4
) (
    input logic             i_clk,
    input logic             i_res_n,
    ram_port_arbiter_if.slave bus
);
    localparam int RW = REQ_NUM > 1 ? $clog2(REQ_NUM) : 1;
    localparam int AW = ACCESS_NUMBER > 1 ? $clog2(ACCESS_NUMBER) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                                     state;
    logic                                       init_cnt;
    logic [RW-1:0]                              ptr;
    logic [RW-1:0]                              k;
    logic [REQ_NUM-1:0]                         ready_c;
    logic [REQ_NUM-1:0]                         oor_c;
    logic [REQ_NUM-1:0]                         rsp_v_q;
    logic [REQ_NUM-1:0]                         err_q;
    logic [REQ_NUM-1:0]                         oor_rd_q;
    logic [REQ_NUM-1:0][AW-1:0]                 port_c;
    logic [REQ_NUM-1:0][AW-1:0]                 port_q;
    logic [ACCESS_NUMBER-1:0]                   we_c;
    logic [ACCESS_NUMBER-1:0]                   re_c;
    logic [ACCESS_NUMBER-1:0][ADDRESS_SIZE-1:0] addr_c;
    logic [ACCESS_NUMBER-1:0][DATA_SIZE-1:0]    wdata_c;
    logic                                       hit;
    int                                         used;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [RW-1:0] nxt_ptr;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n)
            ptr <= '0;
        else
            ptr <= nxt_ptr;
    end
`endif

    // Out-of-range requests are accepted without a port; in-range ones take the lowest free port
    // unless they would write an address already written this cycle.
    always_comb begin
        ready_c = '0;
        oor_c   = '0;
        port_c  = '0;
        we_c    = '0;
        re_c    = '0;
        addr_c  = '0;
        wdata_c = '0;
        used    = 0;
        hit     = 1'b0;
        k       = '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
        nxt_ptr = ptr;
`endif
        for (int i = 0; i < REQ_NUM; i++) begin
            k = RW'((int'(ptr) + i) % REQ_NUM);
            oor_c[k] = 32'(bus.req_addr[k]) >= DATA_LEN;
            hit = 1'b0;
            for (int p = 0; p < ACCESS_NUMBER; p++)
                hit = hit | (we_c[p] & (addr_c[p] == bus.req_addr[k]));
            if (state == RUN && bus.req_valid[k] && oor_c[k])
                ready_c[k] = 1'b1;
            else if (state == RUN && bus.req_valid[k] && used < ACCESS_NUMBER && !(bus.req_we[k] && hit)) begin
                ready_c[k]         = 1'b1;
                port_c[k]          = AW'(used);
                we_c[AW'(used)]    = bus.req_we[k];
                re_c[AW'(used)]    = !bus.req_we[k];
                addr_c[AW'(used)]  = bus.req_addr[k];
                wdata_c[AW'(used)] = bus.req_we[k] ? bus.req_wdata[k] : '0;
                used++;
`ifndef RAM_ARB_FIXED_PRIO_EN
                nxt_ptr = RW'((int'(k) + 1) % REQ_NUM);
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state         <= INIT;
            init_cnt      <= 1'b0;
            bus.o_ram_res <= 1'b1;
            rsp_v_q       <= '0;
            err_q         <= '0;
            oor_rd_q      <= '0;
            port_q        <= '0;
        end else begin
            init_cnt      <= state == INIT;
            state         <= (state == INIT && init_cnt) ? RUN : state;
            bus.o_ram_res <= state == INIT && !init_cnt;
            rsp_v_q       <= ready_c & ~bus.req_we;
            err_q         <= ready_c & oor_c;
            oor_rd_q      <= ready_c & oor_c & ~bus.req_we;
            port_q        <= port_c;
        end
    end

    always_comb begin
        bus.rsp_data = '0;
        for (int j = 0; j < REQ_NUM; j++)
            bus.rsp_data[j] = (rsp_v_q[j] && !oor_rd_q[j]) ? bus.ram_rdata[port_q[j]] : '0;
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_v_q;
    assign bus.o_err     = err_q;
    assign bus.ram_we    = we_c;
    assign bus.ram_re    = re_c;
    assign bus.ram_addr  = addr_c;
    assign bus.ram_wdata = wdata_c;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed plus random traffic against a queue-free reference of the arbitration rules.
module tb_ram_port_arbiter;
    localparam int AS = 8, DS = 8, DL = 200, AN = 2, RN = 4;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ram_port_arbiter_if #(.ADDRESS_SIZE(AS), .DATA_SIZE(DS), .ACCESS_NUMBER(AN), .REQ_NUM(RN)) bus();

    ram_port_arbiter #(.ADDRESS_SIZE(AS), .DATA_SIZE(DS), .DATA_LEN(DL), .ACCESS_NUMBER(AN), .REQ_NUM(RN)) dut (
        .i_clk(clk),
        .i_res_n(res_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // RAM with synchronous clear, registered read-before-write ports
    logic [DS-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (bus.o_ram_res) begin
            for (int a = 0; a < 256; a++) ram_mem[a] <= '0;
            bus.ram_rdata <= '0;
        end else begin
            for (int p = 0; p < AN; p++) begin
                if (bus.ram_re[p]) bus.ram_rdata[p] <= ram_mem[bus.ram_addr[p]];
                if (bus.ram_we[p]) ram_mem[bus.ram_addr[p]] <= bus.ram_wdata[p];
            end
        end
    end

    logic [RN-1:0] rv, rwe, acc, obs_ready, e_rsp_v, e_err;
    logic [AN-1:0] obs_re;
    logic [AS-1:0] raddr [RN];
    logic [DS-1:0] rwd [RN];
    logic [DS-1:0] e_rsp_d [RN];
    logic [DS-1:0] exp_mem [256];
    int            mptr, init_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mptr = 0;
        init_left = 2;
        e_rsp_v = '0;
        e_err = '0;
        for (int k = 0; k < RN; k++) e_rsp_d[k] = '0;
        for (int a = 0; a < 256; a++) exp_mem[a] = '0;
    endtask

    task automatic step();
        logic [RN-1:0] e_ready;
        logic [AN-1:0] e_we, e_re;
        logic [AS-1:0] e_addr [AN];
        logic [DS-1:0] e_wd [AN];
        int used, last;
        bit busy;
        bus.req_valid = rv;
        bus.req_we = rwe;
        for (int k = 0; k < RN; k++) begin
            bus.req_addr[k] = raddr[k];
            bus.req_wdata[k] = rwd[k];
        end
        #1;
        chk("o_ram_res", 32'(bus.o_ram_res), (init_left > 0) ? 32'd1 : 32'd0);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp_v));
        chk("o_err", 32'(bus.o_err), 32'(e_err));
        for (int k = 0; k < RN; k++) chk($sformatf("rsp_data[%0d]", k), 32'(bus.rsp_data[k]), 32'(e_rsp_d[k]));
        e_ready = '0; e_we = '0; e_re = '0; used = 0; last = -1;
        for (int p = 0; p < AN; p++) begin e_addr[p] = '0; e_wd[p] = '0; end
        if (init_left == 0) begin
            for (int i = 0; i < RN; i++) begin
                int k;
                k = (mptr + i) % RN;
                if (!rv[k]) continue;
                if (int'(raddr[k]) >= DL) begin
                    e_ready[k] = 1'b1;
                    continue;
                end
                busy = 1'b0;
                for (int p = 0; p < used; p++) if (rwe[k] && e_we[p] && e_addr[p] == raddr[k]) busy = 1'b1;
                if (used < AN && !busy) begin
                    e_ready[k] = 1'b1;
                    e_we[used] = rwe[k];
                    e_re[used] = !rwe[k];
                    e_addr[used] = raddr[k];
                    e_wd[used] = rwd[k];
                    used++;
                    last = k;
                end
            end
        end
        obs_ready = bus.req_ready;
        obs_re = bus.ram_re;
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        for (int p = 0; p < AN; p++) begin
            chk($sformatf("ram_we[%0d]", p), 32'(bus.ram_we[p]), 32'(e_we[p]));
            chk($sformatf("ram_re[%0d]", p), 32'(bus.ram_re[p]), 32'(e_re[p]));
            chk($sformatf("ram_addr[%0d]", p), 32'(bus.ram_addr[p]), 32'(e_addr[p]));
            if (!e_re[p]) chk($sformatf("ram_wdata[%0d]", p), 32'(bus.ram_wdata[p]), e_we[p] ? 32'(e_wd[p]) : 32'd0);
        end
        @(posedge clk);
        for (int k = 0; k < RN; k++) begin
            e_rsp_v[k] = e_ready[k] & ~rwe[k];
            e_err[k] = e_ready[k] && int'(raddr[k]) >= DL;
            e_rsp_d[k] = (e_ready[k] && !rwe[k] && int'(raddr[k]) < DL) ? exp_mem[raddr[k]] : '0;
        end
        for (int p = 0; p < AN; p++) if (e_we[p]) exp_mem[e_addr[p]] = e_wd[p];
        if (!res_n) model_reset();
        else begin
            if (init_left > 0) init_left--;
`ifndef RAM_ARB_FIXED_PRIO_EN
            if (last >= 0) mptr = (last + 1) % RN;
`endif
        end
        acc = e_ready;
        @(negedge clk);
    endtask

    task automatic rand_run(input int n);
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < RN; k++) begin
                if (!rv[k] && $urandom_range(0, 2) != 0) begin
                    rv[k] = 1'b1;
                    rwe[k] = 1'($urandom_range(0, 1));
                    raddr[k] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(DL, 255)) : 8'($urandom_range(0, 15));
                    rwd[k] = 8'($urandom);
                end
            end
            step();
            rv = rv & ~acc;
        end
    endtask

    initial begin
        rv = '0; rwe = '0; acc = '0;
        for (int k = 0; k < RN; k++) begin raddr[k] = 8'(k); rwd[k] = '0; end
        model_reset();
        @(negedge clk);
        // reset and INIT: all requesters read
        rv = '1;
        repeat (3) step();
        res_n = 1'b1;
        repeat (2) step();
        step();
        chk("first_grant", 32'(obs_ready), 32'h3);
        chk("first_ports", 32'(obs_re), 32'h3);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < RN; k++) if (acc[k]) raddr[k] = raddr[k] + 8'd4;
            step();
`ifdef RAM_ARB_FIXED_PRIO_EN
            chk("fixed_pair", 32'(obs_ready), 32'h3);
`else
            chk("rr_pair", 32'(obs_ready), (r % 2 == 0) ? 32'hC : 32'h3);
`endif
        end
        rv = '0;
        step();
        // write conflict
        rv = 4'b0011; rwe = 4'b0011;
        raddr[0] = 8'h10; rwd[0] = 8'hAA; raddr[1] = 8'h10; rwd[1] = 8'h55;
        step();
        chk("wconf_first", 32'(obs_ready), 32'h1);
        rv = rv & ~acc;
        step();
        chk("wconf_second", 32'(obs_ready), 32'h2);
        rv = 4'b0100; rwe = '0; raddr[2] = 8'h10;
        step();
        chk("wconf_read", 32'(bus.rsp_data[2]), 32'h55);
        // read during write
        rv = 4'b0001; rwe = 4'b0001; raddr[0] = 8'h20; rwd[0] = 8'h11;
        step();
        rv = 4'b0011; rwe = 4'b0001; rwd[0] = 8'h22; raddr[1] = 8'h20;
        step();
        chk("rdw_ready", 32'(obs_ready), 32'h3);
        chk("rdw_old", 32'(bus.rsp_data[1]), 32'h11);
        rv = 4'b0010; rwe = '0;
        step();
        chk("rdw_new", 32'(bus.rsp_data[1]), 32'h22);
        // out of range
        rv = 4'b0111; rwe = '0; raddr[0] = 8'h10; raddr[1] = 8'h20; raddr[2] = 8'hC8;
        step();
        chk("oor_ready", 32'(obs_ready), 32'h7);
        chk("oor_ports", 32'(obs_re), 32'h3);
        chk("oor_err", 32'(bus.o_err), 32'h4);
        chk("oor_rsp_valid", 32'(bus.rsp_valid), 32'h7);
        chk("oor_rsp_data", 32'(bus.rsp_data[2]), 32'h0);
        chk("oor_other_data", 32'(bus.rsp_data[0]), 32'h55);
        rv = '0;
        step();
        rand_run(300);
        // async reset with reads outstanding
        rv = '1; rwe = '0;
        step();
        #3;
        chk("pre_rst_rsp", 32'(bus.rsp_valid), 32'(e_rsp_v));
        res_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_ram_re", 32'(bus.ram_re), 32'h0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_ram_res", 32'(bus.o_ram_res), 32'h1);
        model_reset();
        @(negedge clk);
        repeat (2) step();
        res_n = 1'b1;
        rand_run(100);
        rv = '0;
        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the ACCESS_NUMBER ports of the multi-port waveform RAM between REQ_NUM requesters (sample players, loader, CPU bridge).
- Per-requester valid/ready request channel with a 1-cycle read response.
- Never issues two same-cycle writes to one address, never forwards out-of-range addresses.
- Owns the RAM's synchronous reset sequencing.

Parameters:
ADDRESS_SIZE, 8, RAM address width
DATA_SIZE, 8, RAM word width
DATA_LEN, 256, valid RAM words; legal addresses are 0..DATA_LEN-1
ACCESS_NUMBER, 2, RAM ports available per cycle
REQ_NUM, 4, number of requesters (must be >= ACCESS_NUMBER)

Ports:
i_clk  in  1  clock
i_res_n  in  1  asynchronous active-low reset
req_valid  in  [REQ_NUM]  request present
req_we  in  [REQ_NUM]  1 = write, 0 = read
req_addr  in  [REQ_NUM] x ADDRESS_SIZE  request address
req_wdata  in  [REQ_NUM] x DATA_SIZE  write data
req_ready  out  [REQ_NUM]  request accepted this cycle (combinational)
rsp_valid  out  [REQ_NUM]  read data valid
rsp_data  out  [REQ_NUM] x DATA_SIZE  read data
o_err  out  [REQ_NUM]  1-cycle pulse: accepted request had addr >= DATA_LEN
o_ram_res  out  1  RAM synchronous reset (active high)
ram_addr  out  [ACCESS_NUMBER] x ADDRESS_SIZE  RAM port address
ram_wdata  out  [ACCESS_NUMBER] x DATA_SIZE  RAM port write data
ram_we  out  [ACCESS_NUMBER]  RAM port write enable
ram_re  out  [ACCESS_NUMBER]  RAM port read enable
ram_rdata  in  [ACCESS_NUMBER] x DATA_SIZE  RAM registered read data

Behaviour:
- Clocking: one clock (i_clk). Reset is asynchronous, active-low (i_res_n).
- Reset (i_res_n=0):
  - all req_ready, rsp_valid and o_err are 0; rsp_data is 0;
  - ram_we/ram_re are 0; ram_addr/ram_wdata are 0;
  - round-robin pointer is 0;
  - o_ram_res=1.
- Reset release:
  - o_ram_res stays 1 for exactly 2 i_clk rising edges after i_res_n deasserts (INIT state), then 0 (RUN state).
  - No grants in INIT.
  - Reset mid-operation: pending responses are dropped.
- Arbitration, each RUN cycle, combinational:
  - Scan requesters starting at the pointer, wrapping modulo REQ_NUM.
  - Grant each valid requester in scan order until ACCESS_NUMBER RAM ports are used.
  - Granted requester k gets the lowest free port.
  - Write conflict: a write whose addr equals a write already granted this cycle is skipped (ready=0, retries later). Reads to the same address as a write are allowed; the read returns the old data (RAM read-before-write).
  - Out-of-range request (addr >= DATA_LEN): ready=1 without consuming a port. o_err[k] pulses the next cycle. If it is a read, rsp_valid[k] also pulses the next cycle with rsp_data[k]=0.
  - Unused ports: we=re=0, addr/wdata=0.
- Pointer update, registered:
  - If any in-range grant occurred, the pointer becomes (index of last granted requester + 1) mod REQ_NUM.
  - Otherwise it is unchanged.
- Read response:
  - Port-to-requester map and read flag are registered at acceptance.
  - On the next cycle, rsp_valid[k]=1 and rsp_data[k]=ram_rdata[port]; both are held for exactly 1 cycle.
  - Latency is 1 cycle, with no backpressure on responses.
  - A write produces no response.
- Requesters may hold req_valid with changing fields only until ready. After acceptance the request is consumed; a new request may be presented the next cycle.
- Back-to-back full throughput: ACCESS_NUMBER accepts per cycle sustained.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: the scan always starts at requester 0 (fixed priority, lowest index wins); the pointer register is removed.
- Undefined: round-robin as specified above.
- Conflict, error and response rules are identical in both builds.

Test Plan:
- Reset/INIT: hold i_res_n=0 for 3 cycles, release, all 4 req_valid=1 reads -> o_ram_res=1 for 2 edges after release, req_ready=0 during INIT, first grants to requesters 0,1 on ports 0,1.
- Round-robin fairness: all 4 requesters read continuously -> grant pairs {0,1},{2,3},{0,1}...; each rsp_valid one cycle after its ready. With RAM_ARB_FIXED_PRIO_EN defined -> always {0,1}, while 2 and 3 starve.
- Write conflict: req0 write 0x10=0xAA, req1 write 0x10=0x55 same cycle -> only req0 ready. Next cycle req1 ready. A subsequent read of 0x10 returns 0x55.
- Read-during-write: preload 0x20=0x11; req0 writes 0x20=0x22 while req1 reads 0x20 -> both ready; req1 rsp_data=0x11. A read the next cycle returns 0x22.
- Out of range: DATA_LEN=200, req2 reads 0xC8 -> ready same cycle with no RAM port used; next cycle o_err[2]=1, rsp_valid[2]=1, rsp_data=0. Other requesters still get both ports.
- Async reset mid-traffic: assert i_res_n=0 between edges with reads outstanding -> rsp_valid and ram_we/ram_re drop to 0 immediately; no stale response after release.
